// File: rtl/i2c_master_ctrl.sv
// I2C master sequencing controller: SCL generation, phase sequencing,
// SDA direction and host status for 1-8 byte read/write bursts.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       rw,
    input  logic [2:0] nbytes,
    input  logic       sda_in,
    output logic       i2c_scl,
    output logic       i2c_scl_en,
    output logic       i2c_write_en,
    output logic [7:0] state,
    output logic [3:0] count,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       data_req,
    output logic       rd_valid
);

    typedef enum logic [7:0] {
        ST_IDLE        = 8'd0,
        ST_START       = 8'd1,
        ST_ADDRESS     = 8'd2,
        ST_READ_ACK    = 8'd3,
        ST_WRITE_DATA  = 8'd4,
        ST_READ_ACK2   = 8'd5,
        ST_READ_DATA   = 8'd6,
        ST_WRITE_ACK2  = 8'd7,
        ST_STOP        = 8'd8
    } state_t;

    localparam int DW = $clog2(CLK_DIV);
    localparam int FW = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FREE_LAST = FW'(2 * CLK_DIV - 1);

    state_t      st_q;
    state_t      st_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        rw_q;
    logic        rw_d;
    logic [2:0]  left_q;
    logic [2:0]  left_d;
    logic        busy_d;
    logic        done_d;
    logic        ack_d;
    logic        req_d;
    logic        rdv_d;

    logic [DW-1:0] div_q;
    logic [FW-1:0] free_q;
    logic          scl_q;
    logic          scl_on;
    logic          wen;
    logic          wrap;
    logic          rise;
    logic          free_tick;
    logic          tick;

    always_comb begin
        scl_on = 1'b0;
        wen    = 1'b0;
        unique case (st_q)
            ST_START, ST_STOP: begin
                wen = 1'b1;
            end
            ST_ADDRESS, ST_WRITE_DATA, ST_WRITE_ACK2: begin
                scl_on = 1'b1;
                wen    = 1'b1;
            end
            ST_READ_ACK, ST_READ_ACK2, ST_READ_DATA: begin
                scl_on = 1'b1;
            end
            default: begin
                scl_on = 1'b0;
                wen    = 1'b0;
            end
        endcase
    end

    assign wrap      = scl_on && (div_q == DIV_LAST);
    assign rise      = wrap && !scl_q;
    assign free_tick = !scl_on && (free_q == FREE_LAST);
    assign tick      = rise || free_tick;

    // The free counter paces START/STOP/IDLE while SCL is parked high.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_q  <= '0;
            free_q <= '0;
            scl_q  <= 1'b1;
        end else if (scl_on) begin
            free_q <= '0;
            if (wrap) begin
                div_q <= '0;
                scl_q <= ~scl_q;
            end else begin
                div_q <= div_q + DW'(1);
            end
        end else begin
            div_q  <= '0;
            scl_q  <= 1'b1;
            free_q <= free_tick ? '0 : free_q + FW'(1);
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        rw_d   = rw_q;
        left_d = left_q;
        busy_d = busy;
        ack_d  = ack_err;
        done_d = 1'b0;
        req_d  = 1'b0;
        rdv_d  = 1'b0;

        if (st_q == ST_IDLE && !busy && start) begin
            rw_d   = rw;
            left_d = nbytes;
            busy_d = 1'b1;
            ack_d  = 1'b0;
        end

        if (tick) begin
            unique case (st_q)
                ST_IDLE: begin
                    if (busy) st_d = ST_START;
                end
                ST_START: begin
                    st_d  = ST_ADDRESS;
                    cnt_d = 4'd7;
                end
                ST_ADDRESS: begin
                    if (cnt_q == 4'd0) st_d = ST_READ_ACK;
                    else               cnt_d = cnt_q - 4'd1;
                end
                ST_READ_ACK: begin
                    if (sda_in) begin
                        ack_d = 1'b1;
                        st_d  = ST_STOP;
                        cnt_d = 4'd0;
                    end else begin
                        st_d  = rw_q ? ST_READ_DATA
                                     : ST_WRITE_DATA;
                        cnt_d = 4'd7;
                    end
                end
                ST_WRITE_DATA: begin
                    if (cnt_q == 4'd0) st_d = ST_READ_ACK2;
                    else               cnt_d = cnt_q - 4'd1;
                end
                ST_READ_ACK2: begin
                    if (sda_in) begin
                        ack_d = 1'b1;
                        st_d  = ST_STOP;
                        cnt_d = 4'd0;
                    end else begin
                        left_d = left_q - 3'd1;
                        if (left_q != 3'd0) begin
                            st_d  = ST_WRITE_DATA;
                            cnt_d = 4'd7;
                            req_d = 1'b1;
                        end else begin
                            st_d  = ST_STOP;
                            cnt_d = 4'd0;
                        end
                    end
                end
                ST_READ_DATA: begin
                    if (cnt_q == 4'd0) begin
                        st_d  = ST_WRITE_ACK2;
                        rdv_d = 1'b1;
                        cnt_d = (left_q == 3'd0) ? 4'd0 : 4'd1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_WRITE_ACK2: begin
                    left_d = left_q - 3'd1;
                    if (left_q != 3'd0) begin
                        st_d  = ST_READ_DATA;
                        cnt_d = 4'd7;
                    end else begin
                        st_d  = ST_STOP;
                        cnt_d = 4'd0;
                    end
                end
                ST_STOP: begin
                    st_d   = ST_IDLE;
                    cnt_d  = 4'd0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                default: begin
                    st_d   = ST_IDLE;
                    cnt_d  = 4'd0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            st_q     <= ST_IDLE;
            cnt_q    <= 4'd0;
            rw_q     <= 1'b0;
            left_q   <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            data_req <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            left_q   <= left_d;
            busy     <= busy_d;
            done     <= done_d;
            ack_err  <= ack_d;
            data_req <= req_d;
            rd_valid <= rdv_d;
        end
    end

    assign state        = st_q;
    assign count        = cnt_q;
    assign i2c_scl      = scl_q;
    assign i2c_scl_en   = scl_on;
    assign i2c_write_en = wen;

endmodule
